// File: rtl/pkt_capture_writer_if.sv
// Packet stream in (Avalon-ST sink side) and SDRAM write port out (Avalon-MM master side).
// master = capture writer's view, slave = the MAC/SDRAM environment's view.
interface pkt_capture_writer_if #(
    parameter int N = 32
);
    logic [N-1:0] st_data;
    logic         st_valid;
    logic         st_sop;
    logic         st_eop;
    logic         st_ready;
    logic [N-1:0] m_address;
    logic         m_write;
    logic [N-1:0] m_writedata;
    logic         m_waitrequest;

    modport master (
        input  st_data, st_valid, st_sop, st_eop, m_waitrequest,
        output st_ready, m_address, m_write, m_writedata
    );

    modport slave (
        output st_data, st_valid, st_sop, st_eop, m_waitrequest,
        input  st_ready, m_address, m_write, m_writedata
    );
endinterface

// File: rtl/pkt_capture_writer.sv
// Captures one packet into a host buffer via Avalon-MM writes; CAPTURE_IRQ_EN adds a DONE-entry pulse on irq.
// Latency: beat accepted at t -> write request at t+1; START edge -> ARMED (or DONE if limit 0) in 1 cycle.
// Backpressure: st_ready drops while the single outstanding write is stalled, after the last beat, and on ABORT.
module pkt_capture_writer #(
    parameter int N = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         in_control,
    input  logic [N-1:0]         in_pkt_addr,
    input  logic [N-1:0]         in_pkt_len,
    pkt_capture_writer_if.master bus,
    output logic [1:0]           state,
    output logic [N-1:0]         captured_len,
    output logic                 overflow,
    output logic                 irq
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ARMED   = 2'b01,
        S_CAPTURE = 2'b10,
        S_DONE    = 2'b11
    } state_t;

    localparam logic [N-1:0] WORD = N'(4);

    state_t       st_q;
    logic         start_q;
    logic         accepting;
    logic         draining;
    logic         aborting;
    logic [N-1:0] base;
    logic [N-1:0] limit;
    logic [N-1:0] offset;
    logic [N-1:0] addr_q;
    logic [N-1:0] wdata_q;
    logic         write_q;

    logic         start;
    logic         abort;
    logic         start_rise;
    logic         wr_done;
    logic         ready;
    logic         take;
    logic         at_limit;
    logic [N-1:0] limit_in;
    logic [N-1:0] offset_nxt;
    logic         unused_bits;

    assign start      = in_control[2];
    assign abort      = in_control[3];
    assign start_rise = start && !start_q;
    assign limit_in   = {in_pkt_len[N-1:2], 2'b00};
    assign offset_nxt = offset + WORD;
    assign at_limit   = (offset_nxt == limit);
    assign wr_done    = write_q && !bus.m_waitrequest;
    // ABORT gates ready combinationally so no beat slips in on the abort cycle.
    assign ready      = accepting && !abort && (!write_q || !bus.m_waitrequest);
    assign take       = bus.st_valid && ready && ((st_q == S_CAPTURE) || bus.st_sop);
    assign unused_bits = ^{in_control[N-1:4], in_control[1:0], in_pkt_addr[1:0], in_pkt_len[1:0]};

    assign bus.st_ready    = ready;
    assign bus.m_address   = addr_q;
    assign bus.m_writedata = wdata_q;
    assign bus.m_write     = write_q;
    assign state           = st_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            st_q         <= S_IDLE;
            start_q      <= 1'b0;
            accepting    <= 1'b0;
            draining     <= 1'b0;
            aborting     <= 1'b0;
            base         <= '0;
            limit        <= '0;
            offset       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            captured_len <= '0;
            overflow     <= 1'b0;
        end else begin
            start_q <= start;
            if (wr_done)
                write_q <= 1'b0;
            if (take) begin
                addr_q       <= base + offset;
                wdata_q      <= bus.st_data;
                write_q      <= 1'b1;
                offset       <= offset_nxt;
                captured_len <= captured_len + WORD;
            end
            case (st_q)
                S_IDLE: begin
                    if (start_rise) begin
                        base         <= {in_pkt_addr[N-1:2], 2'b00};
                        limit        <= limit_in;
                        offset       <= '0;
                        captured_len <= '0;
                        overflow     <= 1'b0;
                        draining     <= 1'b0;
                        aborting     <= 1'b0;
                        if (limit_in == '0) begin
                            st_q <= S_DONE;
                        end else begin
                            st_q      <= S_ARMED;
                            accepting <= 1'b1;
                        end
                    end
                end
                S_ARMED, S_CAPTURE: begin
                    if (abort || aborting) begin
                        // Abort is sticky until the outstanding write has been accepted.
                        accepting <= 1'b0;
                        draining  <= 1'b0;
                        if (write_q && bus.m_waitrequest) begin
                            aborting <= 1'b1;
                        end else begin
                            aborting <= 1'b0;
                            st_q     <= S_IDLE;
                        end
                    end else begin
                        if (take) begin
                            st_q <= S_CAPTURE;
                            if (bus.st_eop || at_limit) begin
                                accepting <= 1'b0;
                                draining  <= 1'b1;
                            end
                            if (!bus.st_eop && at_limit)
                                overflow <= 1'b1;
                        end
                        if (draining && wr_done) begin
                            st_q     <= S_DONE;
                            draining <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    if (!start)
                        st_q <= S_IDLE;
                end
                default: st_q <= S_IDLE;
            endcase
        end
    end

`ifdef CAPTURE_IRQ_EN
    logic done_entry;

    assign done_entry = ((st_q == S_IDLE) && start_rise && (limit_in == '0)) ||
                        (((st_q == S_ARMED) || (st_q == S_CAPTURE)) && !abort && !aborting &&
                         draining && wr_done);

    always_ff @(posedge clk) begin
        if (!reset)
            irq <= 1'b0;
        else
            irq <= done_entry;
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_pkt_capture_writer.sv
// Directed bench for pkt_capture_writer: a queue-based capture model predicts every SDRAM write and final status.
module tb_pkt_capture_writer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] in_control;
    logic [31:0] in_pkt_addr;
    logic [31:0] in_pkt_len;
    logic [1:0]  state;
    logic [31:0] captured_len;
    logic        overflow;
    logic        irq;

    pkt_capture_writer_if #(.N(32)) bus ();

    pkt_capture_writer #(.N(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_control   (in_control),
        .in_pkt_addr  (in_pkt_addr),
        .in_pkt_len   (in_pkt_len),
        .bus          (bus),
        .state        (state),
        .captured_len (captured_len),
        .overflow     (overflow),
        .irq          (irq)
    );

    int checks = 0;
    int fails  = 0;
    bit mon_en = 1'b0;
    int irq_cnt = 0;
    int wr_cnt = 0;
    int stall_idx = -1;
    int stall_left = 0;

    logic [31:0] pkt_dat [16];
    bit          pkt_sop [16];
    bit          pkt_eop [16];

    logic [31:0] exp_addr_q [$];
    logic [31:0] exp_dat_q  [$];
    logic [31:0] exp_len;
    logic [31:0] exp_limit;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    bit          exp_ovf;
    bit          exp_done;
    int          exp_consumed;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, got, expv);
        end
    endtask

    task automatic set_beat(input int i, input logic [31:0] d, input bit sop, input bit eop);
        pkt_dat[i] = d;
        pkt_sop[i] = sop;
        pkt_eop[i] = eop;
    endtask

    // Capture rules: skip until first sop, take beats until eop or buffer full, or until abort.
    task automatic model_capture(input logic [31:0] addr, input logic [31:0] len, input int nb,
                                 input int abort_after);
        logic [31:0] base;
        int          taken;
        bit          started;
        base  = addr & 32'hFFFF_FFFC;
        exp_limit = len & 32'hFFFF_FFFC;
        exp_addr_q.delete();
        exp_dat_q.delete();
        exp_ovf = 1'b0;
        exp_consumed = 0;
        exp_first = 32'h0;
        exp_last = 32'h0;
        taken = 0;
        started = 1'b0;
        if (exp_limit != 0) begin
            for (int i = 0; i < nb; i++) begin
                if (abort_after > 0 && taken == abort_after) break;
                exp_consumed++;
                if (!started && !pkt_sop[i]) continue;
                started = 1'b1;
                exp_addr_q.push_back(base + 32'(4 * taken));
                exp_dat_q.push_back(pkt_dat[i]);
                taken++;
                if (pkt_eop[i]) break;
                if (32'(4 * taken) == exp_limit) begin
                    exp_ovf = 1'b1;
                    break;
                end
            end
        end
        if (taken > 0) begin
            exp_first = exp_addr_q[0];
            exp_last  = exp_addr_q[taken-1];
        end
        exp_len  = 32'(4 * taken);
        exp_done = !(abort_after > 0);
    endtask

    // Slave stall generator: holds waitrequest on write number stall_idx for stall_left cycles.
    initial begin
        bus.m_waitrequest = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.m_write && wr_cnt == stall_idx && stall_left > 0) begin
                bus.m_waitrequest = 1'b1;
                stall_left--;
            end else begin
                bus.m_waitrequest = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.m_write && !bus.m_waitrequest) wr_cnt++;
        if (irq) irq_cnt++;
        if (mon_en) begin
            if (bus.m_write) begin
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_write: got write to 0x%h, expected no write", bus.m_address);
                end else begin
                    check("wr_addr", bus.m_address, exp_addr_q[0]);
                    check("wr_data", bus.m_writedata, exp_dat_q[0]);
                    if (!bus.m_waitrequest) begin
                        void'(exp_addr_q.pop_front());
                        void'(exp_dat_q.pop_front());
                    end
                end
                if (bus.m_waitrequest) check("ready_in_stall", {31'b0, bus.st_ready}, 32'd0);
            end
            if (state == 2'd0 || state == 2'd3) check("ready_idle_done", {31'b0, bus.st_ready}, 32'd0);
            if (irq) check("irq_in_done", {30'b0, state}, 32'd3);
        end
    end

    task automatic check_reset_vals(input string nm);
        check({nm, "_state"},   {30'b0, state}, 32'd0);
        check({nm, "_ready"},   {31'b0, bus.st_ready}, 32'd0);
        check({nm, "_m_write"}, {31'b0, bus.m_write}, 32'd0);
        check({nm, "_m_addr"},  bus.m_address, 32'd0);
        check({nm, "_m_data"},  bus.m_writedata, 32'd0);
        check({nm, "_cap_len"}, captured_len, 32'd0);
        check({nm, "_ovf"},     {31'b0, overflow}, 32'd0);
        check({nm, "_irq"},     {31'b0, irq}, 32'd0);
    endtask

    task automatic run_capture(input string nm, input logic [31:0] addr, input logic [31:0] len,
                               input int nb, input int abort_after, input int s_idx, input int s_n);
        int irq0;
        int w;
        int exp_irq;
        logic [1:0] target;
        model_capture(addr, len, nb, abort_after);
        irq0 = irq_cnt;
        stall_idx  = (s_idx < 0) ? -1 : wr_cnt + s_idx;
        stall_left = (s_idx < 0) ? 0 : s_n;
        in_pkt_addr = addr;
        in_pkt_len  = len;
        in_control  = 32'h4;
        @(posedge clk);
        #1;
        check({nm, "_after_start"}, {30'b0, state}, (exp_limit == 0) ? 32'd3 : 32'd1);
        for (int i = 0; i < nb; i++) begin
            if (abort_after > 0 && i == exp_consumed) in_control = 32'hC;
            bus.st_valid = 1'b1;
            bus.st_data  = pkt_dat[i];
            bus.st_sop   = pkt_sop[i];
            bus.st_eop   = pkt_eop[i];
            if (i < exp_consumed) begin
                w = 0;
                do begin
                    @(negedge clk);
                    w++;
                end while (!bus.st_ready && w < 100);
                check({nm, "_beat_accept"}, {31'b0, bus.st_ready}, 32'd1);
                @(posedge clk);
                #1;
            end else begin
                repeat (3) begin
                    @(negedge clk);
                    check({nm, "_ready_low"}, {31'b0, bus.st_ready}, 32'd0);
                end
                @(posedge clk);
                #1;
                break;
            end
        end
        bus.st_valid = 1'b0;
        bus.st_sop   = 1'b0;
        bus.st_eop   = 1'b0;
        target = exp_done ? 2'd3 : 2'd0;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!(state == target && !bus.m_write) && w < 200);
        @(posedge clk);
        #1;
        check({nm, "_state"},   {30'b0, state}, {30'b0, target});
        check({nm, "_cap_len"}, captured_len, exp_len);
        check({nm, "_ovf"},     {31'b0, overflow}, {31'b0, exp_ovf});
        check({nm, "_writes_left"}, 32'(exp_addr_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check({nm, "_hold"}, {30'b0, state}, {30'b0, target});
`ifdef CAPTURE_IRQ_EN
        exp_irq = exp_done ? 1 : 0;
`else
        exp_irq = 0;
`endif
        check({nm, "_irq_count"}, 32'(irq_cnt - irq0), 32'(exp_irq));
        in_control = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check({nm, "_idle"}, {30'b0, state}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b0;
        in_control   = 32'h0;
        in_pkt_addr  = 32'h0;
        in_pkt_len   = 32'h0;
        bus.st_valid = 1'b0;
        bus.st_data  = 32'h0;
        bus.st_sop   = 1'b0;
        bus.st_eop   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        reset = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Plain 4-beat packet into a 64-byte buffer.
        for (int i = 0; i < 4; i++) set_beat(i, 32'hA000_0000 + 32'(i), i == 0, i == 3);
        run_capture("t1", 32'h1000, 32'd64, 4, 0, -1, 0);
        check("t1_model_len", exp_len, 32'd16);
        check("t1_model_first", exp_first, 32'h1000);
        check("t1_model_last", exp_last, 32'h100C);

        // Three stray beats before sop are discarded.
        for (int i = 0; i < 3; i++) set_beat(i, 32'hDEAD_0000 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) set_beat(i + 3, 32'hB000_0000 + 32'(i), i == 0, i == 3);
        run_capture("t2", 32'h1000, 32'd64, 7, 0, -1, 0);
        check("t2_model_len", exp_len, 32'd16);

        // Buffer of 8 bytes truncates a 5-beat packet.
        for (int i = 0; i < 5; i++) set_beat(i, 32'hC000_0000 + 32'(i), i == 0, i == 4);
        run_capture("t3", 32'h1000, 32'd8, 5, 0, -1, 0);
        check("t3_model_len", exp_len, 32'd8);
        check("t3_model_ovf", {31'b0, exp_ovf}, 32'd1);

        // Three-cycle stall on the second write.
        for (int i = 0; i < 4; i++) set_beat(i, 32'hD000_0000 + 32'(i), i == 0, i == 3);
        run_capture("t4", 32'h1000, 32'd64, 4, 0, 1, 3);

        // Abort after two beats while the second write is stalled.
        for (int i = 0; i < 4; i++) set_beat(i, 32'hE000_0000 + 32'(i), i == 0, i == 3);
        run_capture("t5", 32'h1000, 32'd64, 4, 2, 1, 3);
        check("t5_model_len", exp_len, 32'd8);
        check("t5_model_done", {31'b0, exp_done}, 32'd0);

        // Buffer smaller than one word: straight to DONE.
        run_capture("t6", 32'h1000, 32'd3, 0, 0, -1, 0);
        check("t6_model_len", exp_len, 32'd0);

        // Unaligned base, single-beat packet.
        set_beat(0, 32'h1234_5678, 1'b1, 1'b1);
        run_capture("t7", 32'h2003, 32'h13, 1, 0, -1, 0);
        check("t7_model_first", exp_first, 32'h2000);

        // Packet ends exactly at the buffer limit: no overflow.
        for (int i = 0; i < 3; i++) set_beat(i, 32'hF000_0000 + 32'(i), i == 0, i == 2);
        run_capture("t8", 32'h4000, 32'h0F, 3, 0, -1, 0);
        check("t8_model_ovf", {31'b0, exp_ovf}, 32'd0);
        check("t8_model_len", exp_len, 32'd12);

        // Reset while a write is stalled drops it immediately.
        mon_en      = 1'b0;
        stall_idx   = wr_cnt;
        stall_left  = 10;
        in_pkt_addr = 32'h3000;
        in_pkt_len  = 32'd64;
        in_control  = 32'h4;
        @(posedge clk);
        #1;
        bus.st_valid = 1'b1;
        bus.st_data  = 32'h5555_AAAA;
        bus.st_sop   = 1'b1;
        bus.st_eop   = 1'b0;
        @(posedge clk);
        #1;
        bus.st_valid = 1'b0;
        bus.st_sop   = 1'b0;
        check("t9_pending_write", {31'b0, bus.m_write}, 32'd1);
        check("t9_pending_addr", bus.m_address, 32'h3000);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_reset_vals("t9_reset");
        reset      = 1'b1;
        in_control = 32'h0;
        stall_left = 0;
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
